// File: rtl/playback_pkg.sv
// Shared definitions for the playback sequencer.
// Holds the FSM state encoding, the decoded user command type, the default
// timing parameters and the command priority helper used by the top level.
package playback_pkg;

    // clk cycles per duration tick, idle cycles after a note pulse, position width
    localparam int DEF_TICK_DIV = 250000;
    localparam int DEF_SETTLE   = 2;
    localparam int DEF_POS_W    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLAY   = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_REWIND = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_STOP      = 3'd1,
        CMD_PAUSE     = 3'd2,
        CMD_PLAY      = 3'd3,
        CMD_STEP_BACK = 3'd4,
        CMD_STEP_FWD  = 3'd5
    } cmd_t;

    // Collapse simultaneous command pulses to the single winner:
    // stop > pause > play > step_back > step_fwd.
    function automatic cmd_t pick_cmd(input logic stop, input logic pause,
                                      input logic play, input logic step_back,
                                      input logic step_fwd);
        if (stop)
            return CMD_STOP;
        else if (pause)
            return CMD_PAUSE;
        else if (play)
            return CMD_PLAY;
        else if (step_back)
            return CMD_STEP_BACK;
        else if (step_fwd)
            return CMD_STEP_FWD;
        else
            return CMD_NONE;
    endfunction

endpackage

// File: rtl/playback_sequencer_tick_gen.sv
// Duration tick divider.
// Counts enabled clk cycles 0..DIV-1 and raises tick for the cycle in which
// the count sits at DIV-1. Holding enable low freezes the count; clear
// returns it to 0 and wins over enable.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   enable    : count this cycle
//   clear     : force count to 0 at the next edge
//   tick      : single-cycle pulse on the last counted cycle of each period
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/playback_sequencer.sv
// Playback sequencer: walks a note_shifter through a song.
// Times each note in ticks of TICK_DIV clk cycles, pulses note_advance when
// a note's duration expires, supports pause/resume, manual stepping, and a
// rewind that reverses the shifter back to the start of the song before a
// new song selection is applied. After every note pulse the block waits
// SETTLE cycles (shifter ROM latency) before it samples note_dur/next_valid
// or accepts commands again.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   play/pause/stop/step_fwd/back   : single-cycle command pulses
//   song_req                        : requested song
//   note_dur                        : current note duration in ticks (0 = 1)
//   next_valid                      : a note follows the current one
//   note_advance, note_reverse      : single-cycle pulses to note_shifter
//   song_sel                        : song applied to note_shifter
//   playing                         : high exactly in PLAY
//   busy                            : settling after a pulse or rewinding
//   pos                             : notes advanced from song start
//   fsm_state                       : current FSM state for observation
module playback_sequencer
    import playback_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int SETTLE   = DEF_SETTLE,
    parameter int POS_W    = DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             play,
    input  logic             pause,
    input  logic             stop,
    input  logic             step_fwd,
    input  logic             step_back,
    input  logic [1:0]       song_req,
    input  logic [7:0]       note_dur,
    input  logic             next_valid,
    output logic             note_advance,
    output logic             note_reverse,
    output logic [1:0]       song_sel,
    output logic             playing,
    output logic             busy,
    output logic [POS_W-1:0] pos,
    output state_t           fsm_state
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    state_t           state, state_d;
    logic [POS_W-1:0] pos_d;
    logic [SW-1:0]    settle_cnt, settle_d;
    logic [7:0]       dur_cnt, dur_d;
    logic             pending, pend_d;
    logic [1:0]       song_d;

    logic             settling;
    logic             tick, tick_en, tick_clr;
    logic             adv, rev;
    logic             can_adv, expire;
    logic [7:0]       eff_dur;
    cmd_t             cmd;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    assign settling = (settle_cnt != '0);
    assign eff_dur  = (note_dur == 8'd0) ? 8'd1 : note_dur;
    assign can_adv  = next_valid && (pos != {POS_W{1'b1}});
    // Expiry is judged on the tick that completes the last tick of the note,
    // so the pulse lands in the same cycle as that tick.
    assign expire   = tick && (({1'b0, dur_cnt} + 9'd1) >= {1'b0, eff_dur});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pos        <= '0;
            settle_cnt <= '0;
            dur_cnt    <= '0;
            pending    <= 1'b0;
            song_sel   <= 2'd0;
        end else begin
            state      <= state_d;
            pos        <= pos_d;
            settle_cnt <= settle_d;
            dur_cnt    <= dur_d;
            pending    <= pend_d;
            song_sel   <= song_d;
        end
    end

    always_comb begin
        state_d  = state;
        pos_d    = pos;
        dur_d    = dur_cnt;
        pend_d   = pending;
        song_d   = song_sel;
        settle_d = settling ? settle_cnt - 1'b1 : settle_cnt;
        adv      = 1'b0;
        rev      = 1'b0;
        tick_en  = 1'b0;
        tick_clr = 1'b0;
        // Commands that arrive while settling are dropped, not deferred.
        cmd      = settling ? CMD_NONE
                            : pick_cmd(stop, pause, play, step_back, step_fwd);

        if ((state == ST_PLAY || state == ST_PAUSE || state == ST_DONE) &&
            (song_req != song_sel))
            pend_d = 1'b1;

        case (state)
            ST_IDLE: begin
                tick_clr = 1'b1;
                dur_d    = '0;
                if (!settling) begin
                    if (song_req != song_sel && pos != '0) begin
                        // Shifter must be back at note 0 before switching songs.
                        state_d = ST_REWIND;
                        pend_d  = 1'b1;
                    end else begin
                        if (song_req != song_sel)
                            song_d = song_req;
                        case (cmd)
                            CMD_PLAY:      state_d = ST_PLAY;
                            CMD_STEP_FWD:  adv = can_adv;
                            CMD_STEP_BACK: rev = (pos != '0);
                            default: ;
                        endcase
                    end
                end
            end

            ST_PLAY: begin
                tick_en = !settling;
                if (tick)
                    dur_d = dur_cnt + 8'd1;
                if (cmd == CMD_STOP) begin
                    state_d = ST_REWIND;
                end else begin
                    if (expire) begin
                        if (can_adv) begin
                            adv      = 1'b1;
                            dur_d    = '0;
                            tick_clr = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                    // A pause coinciding with expiry still lets the note change.
                    if (cmd == CMD_PAUSE && state_d == ST_PLAY)
                        state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                case (cmd)
                    CMD_STOP: state_d = ST_REWIND;
                    CMD_PLAY: state_d = ST_PLAY;
                    // A manual step starts the new note from a fresh count.
                    CMD_STEP_FWD: begin
                        if (can_adv) begin
                            adv      = 1'b1;
                            dur_d    = '0;
                            tick_clr = 1'b1;
                        end
                    end
                    CMD_STEP_BACK: begin
                        if (pos != '0) begin
                            rev      = 1'b1;
                            dur_d    = '0;
                            tick_clr = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            ST_DONE: begin
                tick_clr = 1'b1;
                dur_d    = '0;
                if (cmd == CMD_PLAY || cmd == CMD_STOP)
                    state_d = ST_REWIND;
            end

            ST_REWIND: begin
                tick_clr = 1'b1;
                dur_d    = '0;
                if (!settling) begin
                    if (pos == '0) begin
                        state_d = ST_IDLE;
                        if (pending)
                            song_d = song_req;
                        pend_d = 1'b0;
                    end else begin
                        rev = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (adv) begin
            pos_d    = pos + 1'b1;
            settle_d = SW'(SETTLE);
        end
        if (rev) begin
            pos_d    = pos - 1'b1;
            settle_d = SW'(SETTLE);
        end
    end

    // Pulses are decoded from live command inputs in IDLE/PAUSE, so they are
    // gated by rst to stay low throughout reset.
    assign note_advance = adv & rst;
    assign note_reverse = rev & rst;
    assign playing      = (state == ST_PLAY);
    assign busy         = settling || (state == ST_REWIND);
    assign fsm_state    = state;

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, clk cycles per duration tick (minimum 2).
REQ-002 SHALL have parameter SETTLE, default 2, idle cycles after any note pulse before note_dur/next_valid are sampled again (note_shifter ROM latency).
REQ-003 SHALL have parameter POS_W, default 9, width of the note position counter.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports play, pause, stop, step_fwd, step_back  input  1 each  single-cycle user command pulses.
REQ-007 SHALL have port song_req  input  2  requested song.
REQ-008 SHALL have port note_dur  input  8  duration of current note in ticks; 0 treated as 1.
REQ-009 SHALL have port next_valid  input  1  a note exists after the current one (note_shifter valid[1]).
REQ-010 SHALL have ports note_advance, note_reverse  output  1 each  single-cycle pulses to note_shifter.
REQ-011 SHALL have port song_sel  output  2  song applied to note_shifter.
REQ-012 SHALL have ports playing, busy  output  1 each; pos  output  POS_W  notes advanced from song start.

Function
REQ-013 SHALL implement states IDLE, PLAY, PAUSE, DONE, REWIND.
REQ-014 Same-cycle command priority SHALL be stop > pause > play > step_back > step_fwd; lower commands are dropped.
REQ-015 IDLE: play -> PLAY with tick_cnt=0, dur_cnt=0; step_fwd -> note_advance if next_valid and pos<max; step_back -> note_reverse if pos>0.
REQ-016 PLAY: tick_cnt counts 0..TICK_DIV-1, each wrap increments dur_cnt; at dur_cnt==max(note_dur,1) with next_valid=1, note_advance pulses, pos increments, dur_cnt and tick_cnt clear.
REQ-017 PLAY: duration expiry with next_valid=0 SHALL go to DONE without a pulse.
REQ-018 PLAY: pause -> PAUSE with counters held; stop -> REWIND.
REQ-019 PAUSE: play resumes PLAY from held counters; step_fwd/step_back act as in IDLE; stop -> REWIND.
REQ-020 DONE: play or stop -> REWIND.
REQ-021 REWIND: one note_reverse pulse every SETTLE+1 cycles with pos decrement while pos>0; at pos==0 -> IDLE.
REQ-022 After any note pulse, counters and sampling SHALL freeze for SETTLE cycles; commands arriving during settle are dropped; busy=1 during settle and REWIND.
REQ-023 Adjacent note pulses SHALL be at least SETTLE+1 cycles apart; note_advance and note_reverse never both high.
REQ-024 pos SHALL saturate: advance suppressed at all-ones, reverse suppressed at 0.
REQ-025 song_req != song_sel in IDLE: pos==0 -> song_sel latched next cycle; pos>0 -> REWIND, latched on exit.
REQ-026 song_req change in PLAY/PAUSE/DONE SHALL set pending; applied on the REWIND exit.
REQ-027 playing SHALL be 1 exactly in PLAY.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, pos=0, counters=0, pending=0, song_sel=0, all pulse outputs 0, playing=0, busy=0.
REQ-029 Reset mid-REWIND or mid-settle SHALL abort without a further pulse.

Structure
REQ-030 State encoding and default TICK_DIV/SETTLE SHALL live in shared package playback_pkg.
REQ-031 Tick divider SHALL be a sub-module tick_gen (enable, clear, tick pulse out).

Verification (TICK_DIV=4, SETTLE=2)
REQ-032 play, note_dur=3, next_valid=1 -> first note_advance 12 cycles after play, pos=1.
REQ-033 pause mid-note, 20 cycles, play -> next note_advance exactly 20 cycles later than uninterrupted.
REQ-034 pos=3, stop -> three note_reverse pulses 3 cycles apart, pos=0, IDLE, busy low after.
REQ-035 next_valid=0 on last note expiry -> DONE, no note_advance, playing=0.
REQ-036 PLAY, song_req 0->2 -> song_sel stays 0; stop -> rewind, song_sel=2 on IDLE entry.
REQ-037 stop and play same cycle in PAUSE -> REWIND; rst low mid-REWIND -> IDLE, pos=0, no pulse.
